// File: rtl/imem_pkg.sv
// Shared types and helpers for the banked boot-loaded instruction memory.
// Optional feature macro: IMEM_PARITY_EN (per-word even parity).
package imem_pkg;
  typedef enum logic [1:0] {CLEAR, LOAD, RUN} state_e;

  // Row-address width of one bank; at least 1 bit so ports stay legal.
  function automatic int row_w(input int depth, input int nbanks);
    int rows;
    rows = depth / nbanks;
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

`ifdef IMEM_PARITY_EN
  function automatic logic parity(input logic [63:0] d);
    return ^d;
  endfunction
`endif
endpackage

// File: rtl/imem_bank.sv
// One instruction-memory bank: one write port, one read-enabled synchronous read port.
// Macro IMEM_PARITY_EN only widens W at the instantiation site.
module imem_bank #(
  parameter int W    = 32,
  parameter int ROWS = 128,
  parameter int RW   = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [RW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [RW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem [ROWS];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // Read register is reset so the fetch output is zero before the first RUN read.
  always_ff @(posedge clk) begin
    if (!rst_n)    rdata_q <= '0;
    else if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/imem_boot_banked.sv
// Banked IF-stage instruction memory with CLEAR -> LOAD -> RUN boot loader.
// Macro IMEM_PARITY_EN adds stored even parity and the parity_err output.
module imem_boot_banked
  import imem_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 256,
  parameter int NUM_BANKS = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              boot_valid,
  output logic              boot_ready,
  input  logic [DATA_W-1:0] boot_data,
  input  logic              boot_last,
  output logic              running,
  input  logic [31:0]       pc,
  input  logic              fetch_stall,
  output logic [DATA_W-1:0] inst,
  output logic              inst_valid
`ifdef IMEM_PARITY_EN
  ,
  output logic              parity_err
`endif
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int BSEL_W = (BANK_W > 0) ? BANK_W : 1;
  localparam int ROWS   = DEPTH / NUM_BANKS;
  localparam int RW     = row_w(DEPTH, NUM_BANKS);
`ifdef IMEM_PARITY_EN
  localparam int MW = DATA_W + 1;
`else
  localparam int MW = DATA_W;
`endif

  // Bank select is the address MSBs; with one bank the shift leaves zero.
  function automatic logic [BSEL_W-1:0] bank_of(input logic [ADDR_W-1:0] a);
    return BSEL_W'(a >> (ADDR_W - BANK_W));
  endfunction

  function automatic logic [RW-1:0] row_of(input logic [ADDR_W-1:0] a);
    return RW'(a & ADDR_W'(ROWS - 1));
  endfunction

  state_e            state_q, state_d;
  logic [RW-1:0]     clr_ptr_q, clr_ptr_d;
  logic [ADDR_W-1:0] boot_ptr_q, boot_ptr_d;
  logic [BSEL_W-1:0] sel_q, sel_d;
  logic              inst_valid_q, inst_valid_d;

  logic [ADDR_W-1:0] pc_addr;
  logic              boot_acc, fetch, clearing;
  logic              unused_pc;

  assign pc_addr    = pc[ADDR_W+1:2];
  assign unused_pc  = ^{pc[31:ADDR_W+2], pc[1:0]};
  assign clearing   = (state_q == CLEAR);
  assign boot_ready = (state_q == LOAD);
  assign running    = (state_q == RUN);
  assign boot_acc   = boot_ready && boot_valid;
  assign fetch      = running && !fetch_stall;

  always_comb begin
    state_d      = state_q;
    clr_ptr_d    = clr_ptr_q;
    boot_ptr_d   = boot_ptr_q;
    sel_d        = sel_q;
    inst_valid_d = inst_valid_q;
    unique case (state_q)
      CLEAR: begin
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == RW'(ROWS - 1)) state_d = LOAD;
      end
      LOAD: begin
        if (boot_acc) begin
          boot_ptr_d = boot_ptr_q + 1'b1;
          // Full image ends the load as well, so the pointer never wraps.
          if (boot_last || boot_ptr_q == ADDR_W'(DEPTH - 1)) state_d = RUN;
        end
      end
      RUN: begin
        if (!fetch_stall) begin
          sel_d        = bank_of(pc_addr);
          inst_valid_d = 1'b1;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= CLEAR;
      clr_ptr_q    <= '0;
      boot_ptr_q   <= '0;
      sel_q        <= '0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_ptr_q    <= clr_ptr_d;
      boot_ptr_q   <= boot_ptr_d;
      sel_q        <= sel_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  logic [MW-1:0]                wdata;
  logic [RW-1:0]                waddr;
  logic [NUM_BANKS-1:0][MW-1:0] rdata;

`ifdef IMEM_PARITY_EN
  assign wdata = clearing ? '0 : {parity(64'(boot_data)), boot_data};
`else
  assign wdata = clearing ? '0 : boot_data;
`endif
  assign waddr = clearing ? clr_ptr_q : row_of(boot_ptr_q);

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic we_b, re_b;
    assign we_b = clearing || (boot_acc && bank_of(boot_ptr_q) == BSEL_W'(b));
    assign re_b = fetch && (bank_of(pc_addr) == BSEL_W'(b));

    imem_bank #(.W(MW), .ROWS(ROWS), .RW(RW)) u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .we_i    (we_b),
      .waddr_i (waddr),
      .wdata_i (wdata),
      .re_i    (re_b),
      .raddr_i (row_of(pc_addr)),
      .rdata_o (rdata[b])
    );
  end

  assign inst       = rdata[sel_q][DATA_W-1:0];
  assign inst_valid = inst_valid_q;
`ifdef IMEM_PARITY_EN
  assign parity_err = rdata[sel_q][DATA_W] ^ parity(64'(rdata[sel_q][DATA_W-1:0]));
`endif
endmodule

// File: tb/tb_imem_boot_banked.sv
// Directed, table-driven bench for imem_boot_banked (default params).
// Parity checks compile only when IMEM_PARITY_EN is defined.
module tb_imem_boot_banked;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        boot_valid = 1'b0, boot_last = 1'b0, fetch_stall = 1'b0;
  logic [31:0] boot_data = '0, pc = '0;
  logic        boot_ready, running, inst_valid;
  logic [31:0] inst;
`ifdef IMEM_PARITY_EN
  logic        parity_err;
`endif

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  imem_boot_banked #(.DATA_W(32), .DEPTH(256), .NUM_BANKS(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .boot_valid  (boot_valid),
    .boot_ready  (boot_ready),
    .boot_data   (boot_data),
    .boot_last   (boot_last),
    .running     (running),
    .pc          (pc),
    .fetch_stall (fetch_stall),
    .inst        (inst),
    .inst_valid  (inst_valid)
`ifdef IMEM_PARITY_EN
    ,
    .parity_err  (parity_err)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic        stall;
    logic [31:0] inst;
    logic        vld;
  } vec_t;

  vec_t v[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    boot_valid = 1'b0;
    boot_last = 1'b0;
    step();
    chk("rst_boot_ready", {31'd0, boot_ready}, 32'd0);
    chk("rst_running",    {31'd0, running},    32'd0);
    chk("rst_inst",       inst,                32'd0);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic wait_ready(input string name, input int exp_cycles);
    int n;
    n = 0;
    while (!boot_ready && n < 1000) begin
      step();
      n++;
    end
    boot_valid = 1'b0;
    chk(name, n, exp_cycles);
  endtask

  task automatic beat(input logic [31:0] d, input logic last);
    boot_valid = 1'b1;
    boot_data  = d;
    boot_last  = last;
    step();
    boot_valid = 1'b0;
    boot_last  = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a, input logic st);
    pc = a;
    fetch_stall = st;
    step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    // Image 0x11,0x22,0x33,0x44 at words 0..3, zeros elsewhere.
    v[0]  = '{32'h008, 1'b0, 32'h33, 1'b1};
    v[1]  = '{32'h000, 1'b0, 32'h11, 1'b1};
    v[2]  = '{32'h004, 1'b0, 32'h22, 1'b1};
    v[3]  = '{32'h00C, 1'b0, 32'h44, 1'b1};
    v[4]  = '{32'h010, 1'b0, 32'h00, 1'b1};
    v[5]  = '{32'h400, 1'b0, 32'h11, 1'b1};  // aliases to word 0
    v[6]  = '{32'h007, 1'b0, 32'h22, 1'b1};  // low pc bits ignored
    v[7]  = '{32'h3FC, 1'b0, 32'h00, 1'b1};
    v[8]  = '{32'h000, 1'b0, 32'h11, 1'b1};
    v[9]  = '{32'h004, 1'b1, 32'h11, 1'b1};  // stalled: hold word 0
    v[10] = '{32'h008, 1'b1, 32'h11, 1'b1};
    v[11] = '{32'h004, 1'b0, 32'h22, 1'b1};

    // Reset, clear timing, and a beat offered during CLEAR is dropped.
    do_reset();
    boot_valid = 1'b1;
    boot_data  = 32'hDEADBEEF;
    wait_ready("clear_cycles", 128);

    beat(32'h11, 1'b0);
    beat(32'h22, 1'b0);
    beat(32'h33, 1'b0);
    chk("load_not_running", {31'd0, running}, 32'd0);
    beat(32'h44, 1'b1);
    chk("run_after_last", {31'd0, running}, 32'd1);
    chk("ready_low_in_run", {31'd0, boot_ready}, 32'd0);
    chk("valid_low_before_fetch", {31'd0, inst_valid}, 32'd0);

    for (int i = 0; i < 12; i++) begin
      fetch(v[i].pc, v[i].stall);
      chk($sformatf("vec%0d_inst", i), inst, v[i].inst);
      chk($sformatf("vec%0d_valid", i), {31'd0, inst_valid}, {31'd0, v[i].vld});
    end

    bad = 0;
    for (int w = 4; w < 256; w++) begin
      fetch(w * 4, 1'b0);
      if (inst !== 32'd0) bad++;
    end
    chk("cleared_words_zero", bad, 0);

    // Full 256-beat image without boot_last; reset taken from RUN.
    do_reset();
    wait_ready("clear_cycles_2", 128);
    for (int i = 0; i < 256; i++) begin
      if (i == 255) chk("not_run_before_256", {31'd0, running}, 32'd0);
      beat(32'hA000_0000 | i, 1'b0);
    end
    chk("run_after_256", {31'd0, running}, 32'd1);
    boot_valid = 1'b1;
    boot_data  = 32'hFFFF_FFFF;
    fetch(32'h3FC, 1'b0);
    chk("word255_bank1", inst, 32'hA000_00FF);
    fetch(32'h1FC, 1'b0);
    chk("word127_bank0", inst, 32'hA000_007F);
    fetch(32'h200, 1'b0);
    chk("word128_bank1", inst, 32'hA000_0080);
    fetch(32'h000, 1'b0);
    chk("no_write_in_run", inst, 32'hA000_0000);
    boot_valid = 1'b0;

    // Reset mid-LOAD discards the partial image.
    do_reset();
    wait_ready("clear_cycles_3", 128);
    beat(32'h55, 1'b0);
    beat(32'h66, 1'b0);
    do_reset();
    wait_ready("clear_cycles_4", 128);
    beat(32'h77, 1'b1);
    chk("reboot_running", {31'd0, running}, 32'd1);
    fetch(32'h004, 1'b0);
    chk("partial_discarded", inst, 32'h0);
    fetch(32'h000, 1'b0);
    chk("reboot_word0", inst, 32'h77);

`ifdef IMEM_PARITY_EN
    chk("parity_ok", {31'd0, parity_err}, 32'd0);
    dut.g_bank[0].u_bank.mem[3][5] = ~dut.g_bank[0].u_bank.mem[3][5];
    fetch(32'h00C, 1'b0);
    chk("parity_flip_inst", inst, 32'h20);
    chk("parity_err_set", {31'd0, parity_err}, 32'd1);
    fetch(32'h010, 1'b1);
    chk("parity_err_hold", {31'd0, parity_err}, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
